// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: combinational stall/flush/forward selects from current inputs and state,
// plus a registered memory-wait FSM, a sticky timeout flag and saturating event counters.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             stall_id_ex,
  output logic             flush_id_ex,
  output logic             stall_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic             mem_timeout
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  // The first stalled cycle is spent in RUN, so wait_cnt lags the stall count by two at the trip edge.
  localparam logic [WC_W-1:0] WC_TRIP = WC_W'(TIMEOUT - 2);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] load_stall_cnt_q, load_stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;

  logic mem_wait, redirect, load_use;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign redirect = ex_pc_src;
  assign load_use = (ex_result_src == 2'b01) & ex_reg_write & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      fwd_sel = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (rst) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
      if (mem_wait) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    mem_timeout_d    = mem_timeout_q;
    load_stall_cnt_d = load_stall_cnt_q;
    redirect_cnt_d   = redirect_cnt_q;
    mem_stall_cnt_d  = mem_stall_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_wait) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          if (wait_cnt_q >= WC_TRIP) mem_timeout_d = 1'b1;
          if (wait_cnt_q < WC_MAX)   wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
    // Counters follow the priority resolution: masked events do not count.
    if (mem_wait)
      mem_stall_cnt_d = sat_inc(mem_stall_cnt_q);
    else if (redirect)
      redirect_cnt_d = sat_inc(redirect_cnt_q);
    else if (load_use)
      load_stall_cnt_d = sat_inc(load_stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      wait_cnt_q       <= '0;
      mem_timeout_q    <= 1'b0;
      load_stall_cnt_q <= '0;
      redirect_cnt_q   <= '0;
      mem_stall_cnt_q  <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      mem_timeout_q    <= mem_timeout_d;
      load_stall_cnt_q <= load_stall_cnt_d;
      redirect_cnt_q   <= redirect_cnt_d;
      mem_stall_cnt_q  <= mem_stall_cnt_d;
    end
  end

  assign load_stall_cnt = load_stall_cnt_q;
  assign redirect_cnt   = redirect_cnt_q;
  assign mem_stall_cnt  = mem_stall_cnt_q;
  assign mem_timeout    = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with CNT_W=3 and TIMEOUT=4 so saturation and timeout are reachable quickly.
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_pc_src, mem_reg_write, wb_reg_write;
  logic dmem_req, dmem_ready;
  logic [1:0] ex_result_src;
  logic stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] load_stall_cnt, redirect_cnt, mem_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex), .stall_ex_mem(stall_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .load_stall_cnt(load_stall_cnt), .redirect_cnt(redirect_cnt), .mem_stall_cnt(mem_stall_cnt),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Packs the six stall/flush outputs as {stall_pc,stall_if_id,stall_id_ex,stall_ex_mem,flush_if_id,flush_id_ex}.
  function automatic int ctl();
    return int'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write = 0; ex_result_src = 2'b00; ex_pc_src = 0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] rd);
    ex_result_src = 2'b01; ex_reg_write = 1; ex_rd = rd; id_rs2 = 5; id_uses_rs2 = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    // Reset forces flushes and blocks stalls/forwarding whatever the inputs say.
    dmem_req = 1; ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1; ex_pc_src = 1;
    step();
    #1;
    chk("rst_ctl", ctl(), 6'b000011);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    step();
    chk("rst_cnt", 32'({load_stall_cnt, redirect_cnt, mem_stall_cnt}), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    rst = 0;
    clr();
    #1;
    chk("idle_ctl", ctl(), 0);

    // Load-use stalls PC/IF-ID and bubbles ID/EX.
    set_load_use(5);
    #1;
    chk("lu_ctl", ctl(), 6'b110001);
    chk("lu_cnt_before", 32'(load_stall_cnt), 0);
    step();
    clr();
    #1;
    chk("lu_cnt_after", 32'(load_stall_cnt), 1);
    set_load_use(0);
    id_rs2 = 0;
    #1;
    chk("lu_x0_ctl", ctl(), 0);
    step();
    clr();
    chk("lu_x0_cnt", 32'(load_stall_cnt), 1);

    // Redirect masks a simultaneous load-use.
    do_reset();
    set_load_use(5);
    ex_pc_src = 1;
    #1;
    chk("redir_ctl", ctl(), 6'b000011);
    step();
    clr();
    chk("redir_cnt", 32'(redirect_cnt), 1);
    chk("redir_lu_cnt", 32'(load_stall_cnt), 0);

    // Memory wait of 3 cycles; a redirect during the wait is ignored.
    do_reset();
    dmem_req = 1; dmem_ready = 0; ex_pc_src = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), ctl(), 6'b111100);
      step();
    end
    dmem_ready = 1;
    #1;
    chk("mw_release_ctl", ctl(), 6'b000011);
    step();
    clr();
    chk("mw_cnt", 32'(mem_stall_cnt), 3);
    chk("mw_redir_cnt", 32'(redirect_cnt), 1);
    chk("mw_no_timeout", 32'(mem_timeout), 0);

    // Timeout after the 4th stalled edge, sticky past release.
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("to_edge%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
    end
    chk("to_still_stalled", ctl(), 6'b111100);
    dmem_ready = 1;
    step();
    clr();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_stall_cnt", 32'(mem_stall_cnt), 6);
    step();
    chk("to_sticky2", 32'(mem_timeout), 1);
    do_reset();
    chk("to_cleared", 32'(mem_timeout), 0);

    // Forwarding priority and x0 exclusion.
    ex_rs1 = 7; ex_rs2 = 7; mem_rd = 7; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
    #1;
    chk("fwd_a_mem", 32'(fwd_a), 2);
    chk("fwd_b_mem", 32'(fwd_b), 2);
    mem_reg_write = 0;
    #1;
    chk("fwd_a_wb", 32'(fwd_a), 1);
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
    #1;
    chk("fwd_a_x0", 32'(fwd_a), 0);
    ex_rs1 = 4; wb_rd = 4; ex_rs2 = 6; mem_rd = 6;
    #1;
    chk("fwd_a_indep", 32'(fwd_a), 1);
    chk("fwd_b_indep", 32'(fwd_b), 2);
    clr();

    // Counter saturation at 2^3-1.
    do_reset();
    set_load_use(5);
    for (int i = 0; i < 9; i++) step();
    clr();
    chk("sat_lu_cnt", 32'(load_stall_cnt), 7);
    chk("sat_redir_cnt", 32'(redirect_cnt), 0);

    // Reset in the middle of a wait aborts it; afterwards the FSM starts from RUN.
    dmem_req = 1; dmem_ready = 0;
    step();
    step();
    chk("mid_pre_cnt", 32'(mem_stall_cnt), 2);
    rst = 1;
    #1;
    chk("mid_rst_ctl", ctl(), 6'b000011);
    step();
    chk("mid_rst_cnt", 32'({load_stall_cnt, redirect_cnt, mem_stall_cnt}), 0);
    chk("mid_rst_ctl2", ctl(), 6'b000011);
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("mid_to_edge%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
    end
    chk("mid_stall_cnt", 32'(mem_stall_cnt), 4);
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall/flush inputs of every inter-stage register (IF/ID, ID/EX, EX/MEM) and the EX-stage forwarding selects.
- Detects load-use hazards, EX-resolved control-flow redirects and data-memory wait states.
- Keeps saturating performance counters and a sticky memory-timeout flag.
- Sits beside the datapath in the RISC-V core. Consumes register indices and control bits from ID/EX/MEM/WB; produces hazard controls only.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, width of each performance counter
- TIMEOUT, 1024, consecutive memory-wait cycles before mem_timeout sets (>=2)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ex_rs1, ex_rs2  in  REG_W  source registers of the instruction in EX
- ex_rd  in  REG_W  EX destination
- ex_reg_write  in  1  EX writes the register file
- ex_result_src  in  2  EX result source; 2'b01 = load
- ex_pc_src  in  1  EX branch taken or jump/jalr resolved
- mem_rd  in  REG_W  MEM destination
- mem_reg_write  in  1  MEM writes the register file
- wb_rd  in  REG_W  WB destination
- wb_reg_write  in  1  WB writes the register file
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID
- stall_id_ex  out  1  hold ID/EX
- flush_id_ex  out  1  clear ID/EX (insert bubble)
- stall_ex_mem  out  1  hold EX/MEM
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM result
- load_stall_cnt, redirect_cnt, mem_stall_cnt  out  CNT_W  saturating event counters
- mem_timeout  out  1  sticky error flag

Behaviour:
- Timing: all hazard outputs are combinational from the current inputs and state, with zero latency. Counters, state and mem_timeout are registered on the clk rising edge.
- Pipeline registers give flush priority over stall. This unit must therefore never assert flush_X and stall_X for the same register in the same cycle.
- Terms:
  - mem_wait = dmem_req & ~dmem_ready.
  - redirect = ex_pc_src.
  - load_use = ex_result_src==01 & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority 1, mem_wait: stall_pc = stall_if_id = stall_id_ex = stall_ex_mem = 1; all flushes 0. Redirect and load_use are ignored because EX is frozen and re-presents them after release.
- Priority 2, redirect: flush_if_id = flush_id_ex = 1; all stalls 0. Redirect overrides load_use, since the ID instruction is wrong-path.
- Priority 3, load_use: stall_pc = stall_if_id = 1, flush_id_ex = 1; others 0.
- Otherwise: all stalls and flushes are 0.
- Forwarding (fwd_a from ex_rs1, fwd_b from ex_rs2, evaluated independently):
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==rs.
  - else 01 if wb_reg_write & wb_rd!=0 & wb_rd==rs.
  - else 00.
  - MEM beats WB on a double match. x0 is never forwarded.
- State machine {RUN, MEM_WAIT}:
  - RUN -> MEM_WAIT when mem_wait.
  - MEM_WAIT -> RUN when ~mem_wait.
  - Release (dmem_ready=1) drops the stalls in the same cycle.
- wait_cnt (registered):
  - Cleared in RUN; increments each MEM_WAIT cycle with mem_wait still true; saturates.
  - When consecutive stalled cycles reach TIMEOUT, mem_timeout sets on that edge and stays 1 until rst.
  - The stall is not broken by the timeout.
- Counters:
  - Each counter increments by 1 per cycle in which its event actually drives outputs. Example: load_use masked by redirect does not count load_stall_cnt.
  - mem_stall_cnt counts every stalled cycle.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Reset (rst=1 at an edge):
  - State goes to RUN; wait_cnt, all counters and mem_timeout go to 0.
  - While rst is high: flush_if_id = flush_id_ex = 1, all stalls 0, fwd_a = fwd_b = 00, regardless of other inputs.
  - Reset mid-MEM_WAIT aborts the wait.

Test Plan:
- Load-use: ex_result_src=01, ex_reg_write=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> stall_pc=stall_if_id=flush_id_ex=1, stall_id_ex=0, load_stall_cnt 0->1. Repeat with ex_rd=0 -> no stall, counter unchanged.
- Redirect plus load_use in the same cycle -> flush_if_id=flush_id_ex=1, all stalls 0, redirect_cnt=1, load_stall_cnt=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> all four stalls high for exactly 3 cycles, flushes 0, ex_pc_src=1 during wait ignored, mem_stall_cnt=3, state back to RUN on the ready cycle.
- Timeout (TIMEOUT=4): hold mem_wait 6 cycles -> mem_timeout rises after the 4th stalled edge, stays 1 after release, clears only on rst.
- Forwarding: ex_rs1=7, mem_rd=7/mem_reg_write=1, wb_rd=7/wb_reg_write=1 -> fwd_a=10. Clear mem_reg_write -> fwd_a=01. Set ex_rs1=0 with matching x0 writers -> fwd_a=00.
- Saturation/reset: CNT_W=3, 9 load-use cycles -> load_stall_cnt=7. Assert rst mid-MEM_WAIT -> counters 0, stalls 0, flushes 1 while rst high, RUN after.
